// File: rtl/clksel_seq_if.sv
// Signal bundle between the clock-select sequencer and its surroundings.
// The master drives configuration, decode and switch feedback; the slave drives the request and status.
interface clksel_seq_if;
    logic       hs_mode_en;
    logic       host_access_req;
    logic       hsclk_selected_in;
    logic       lsclk_selected_in;
    logic       hsclk_sel;
    logic       host_grant;
    logic       switching;
    logic [1:0] clk_state;
    logic       timeout_err;

    modport master (
        output hs_mode_en, host_access_req, hsclk_selected_in, lsclk_selected_in,
        input  hsclk_sel, host_grant, switching, clk_state, timeout_err
    );

    modport slave (
        input  hs_mode_en, host_access_req, hsclk_selected_in, lsclk_selected_in,
        output hsclk_sel, host_grant, switching, clk_state, timeout_err
    );
endinterface

// File: rtl/clksel_seq.sv
// Sequences the CPU clock switch between the host clock (LS) and the high-speed clock (HS).
// Host accesses are granted only once the switch confirms that the host clock is selected.
//
// state | meaning
// LS    | host clock confirmed, host accesses granted, dwell timer running
// TO_HS | high-speed requested, waiting for the switch to acknowledge
// HS    | high-speed clock confirmed
// TO_LS | host clock requested, waiting for the switch to acknowledge
module clksel_seq #(
    parameter int SYNC_STAGES    = 2,
    parameter int HOLD_CYCLES    = 8,
    parameter int TIMEOUT_CYCLES = 200,
    parameter int CNT_W          = 8
) (
    input logic         hsclk_in,
    input logic         rst_b,
    clksel_seq_if.slave bus
);

    localparam logic [1:0] ST_LS    = 2'd0;
    localparam logic [1:0] ST_TO_HS = 2'd1;
    localparam logic [1:0] ST_HS    = 2'd2;
    localparam logic [1:0] ST_TO_LS = 2'd3;

    localparam logic [CNT_W-1:0] HOLD_VAL = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [SYNC_STAGES-1:0] hs_sync_q;
    logic [SYNC_STAGES-1:0] ls_sync_q;
    logic [1:0]             state_q, state_d;
    logic [CNT_W-1:0]       dwell_q, dwell_d;
    logic [CNT_W-1:0]       tmo_q, tmo_d;
    logic                   terr_q, terr_d;
    logic                   hsclk_sel_q;
    logic                   host_grant_q;
    logic                   switching_q;

    logic hs_ack, ls_ack, hs_ok, ls_ok, want_ls;

    assign hs_ack  = hs_sync_q[SYNC_STAGES-1];
    assign ls_ack  = ls_sync_q[SYNC_STAGES-1];
    // A valid acknowledge needs the two feedbacks to disagree.
    assign hs_ok   = hs_ack & ~ls_ack;
    assign ls_ok   = ls_ack & ~hs_ack;
    assign want_ls = bus.host_access_req | ~bus.hs_mode_en;

    always_comb begin
        state_d = state_q;
        dwell_d = dwell_q;
        tmo_d   = tmo_q;
        terr_d  = 1'b0;
        case (state_q)
            ST_LS: begin
                if (want_ls) begin
                    dwell_d = HOLD_VAL;
                end else if (dwell_q != '0) begin
                    dwell_d = dwell_q - CNT_ONE;
                end else begin
                    state_d = ST_TO_HS;
                    tmo_d   = '0;
                end
            end
            ST_TO_HS: begin
                // An abort outranks a simultaneous acknowledge.
                if (want_ls) begin
                    state_d = ST_TO_LS;
                    tmo_d   = '0;
                end else if (hs_ok) begin
                    state_d = ST_HS;
                end else if (tmo_q == TMO_LAST) begin
                    terr_d  = 1'b1;
                    state_d = ST_TO_LS;
                    tmo_d   = '0;
                end else if (tmo_q != CNT_MAX) begin
                    tmo_d = tmo_q + CNT_ONE;
                end
            end
            ST_HS: begin
                if (want_ls) begin
                    state_d = ST_TO_LS;
                    tmo_d   = '0;
                end
            end
            ST_TO_LS: begin
                if (ls_ok) begin
                    state_d = ST_LS;
                    dwell_d = HOLD_VAL;
                end else if (tmo_q == TMO_LAST) begin
                    terr_d = 1'b1;
                    tmo_d  = '0;
                end else if (tmo_q != CNT_MAX) begin
                    tmo_d = tmo_q + CNT_ONE;
                end
            end
            default: state_d = ST_LS;
        endcase
    end

    always_ff @(posedge hsclk_in) begin
        if (!rst_b) begin
            hs_sync_q    <= '0;
            ls_sync_q    <= '0;
            state_q      <= ST_LS;
            dwell_q      <= HOLD_VAL;
            tmo_q        <= '0;
            terr_q       <= 1'b0;
            hsclk_sel_q  <= 1'b0;
            host_grant_q <= 1'b1;
            switching_q  <= 1'b0;
        end else begin
            hs_sync_q    <= {hs_sync_q[SYNC_STAGES-2:0], bus.hsclk_selected_in};
            ls_sync_q    <= {ls_sync_q[SYNC_STAGES-2:0], bus.lsclk_selected_in};
            state_q      <= state_d;
            dwell_q      <= dwell_d;
            tmo_q        <= tmo_d;
            terr_q       <= terr_d;
            // Outputs follow the next state so they change on the same edge as the state.
            hsclk_sel_q  <= (state_d == ST_TO_HS) | (state_d == ST_HS);
            host_grant_q <= (state_d == ST_LS);
            switching_q  <= (state_d == ST_TO_HS) | (state_d == ST_TO_LS);
        end
    end

    assign bus.hsclk_sel   = hsclk_sel_q;
    assign bus.host_grant  = host_grant_q;
    assign bus.switching   = switching_q;
    assign bus.clk_state   = state_q;
    assign bus.timeout_err = terr_q;

endmodule
